// File: rtl/row_emit_mdl_pkg.sv
// Shared definitions for the matrix-to-row serializer and its neighbours
// (row buffer, matrix_mdl): state encoding and width helpers.
package row_emit_mdl_pkg;

    // Serializer state: waiting for a matrix, or streaming its rows out.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } emit_state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

    // Width of one row slice in bits.
    function automatic int row_w(input int data_size, input int row_size);
        return data_size * row_size;
    endfunction

    // Width of a whole matrix word in bits.
    function automatic int mat_w(input int data_size, input int row_size,
                                 input int column_size);
        return data_size * row_size * column_size;
    endfunction

endpackage : row_emit_mdl_pkg

// File: rtl/row_emit_mdl_if.sv
// Matrix load side and row emit side of the serializer, bundled together.
// The slave modport is the serializer itself; master is its environment.
interface row_emit_mdl_if #(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 64,
    parameter int ROW_SIZE    = 64
);
    import row_emit_mdl_pkg::*;

    localparam int ROW_W = row_w(DATA_SIZE, ROW_SIZE);
    localparam int MAT_W = mat_w(DATA_SIZE, ROW_SIZE, COLUMN_SIZE);
    localparam int CW    = clog2(COLUMN_SIZE);

    // Global advance
    logic             enable;
    // Matrix load handshake
    logic             dsetFlag;
    logic [MAT_W-1:0] dats;
    logic             dreadyFlag;
    // Row emit handshake
    logic             dready;
    logic [ROW_W-1:0] datsOut;
    logic             dvalidFlag;
    logic             dendFlag;
    logic [CW-1:0]    rowIdx;

    modport slave (
        input  enable,
        input  dsetFlag,
        input  dats,
        output dreadyFlag,
        input  dready,
        output datsOut,
        output dvalidFlag,
        output dendFlag,
        output rowIdx
    );

    modport master (
        output enable,
        output dsetFlag,
        output dats,
        input  dreadyFlag,
        output dready,
        input  datsOut,
        input  dvalidFlag,
        input  dendFlag,
        input  rowIdx
    );

endinterface : row_emit_mdl_if

// File: rtl/row_emit_mdl.sv
// Matrix-to-row serializer: captures one full matrix word, then emits its
// row slices most-significant first, one per accepted beat, flagging the
// last slice. COLUMN_SIZE must be at least 2.
module row_emit_mdl
    import row_emit_mdl_pkg::*;
#(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 64,
    parameter int ROW_SIZE    = 64
) (
    input  logic           clock,
    input  logic           reset,
    row_emit_mdl_if.slave  bus
);

    localparam int ROW_W = row_w(DATA_SIZE, ROW_SIZE);
    localparam int MAT_W = mat_w(DATA_SIZE, ROW_SIZE, COLUMN_SIZE);
    localparam int CW    = clog2(COLUMN_SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(COLUMN_SIZE - 1);

    emit_state_e      state_q;
    logic [MAT_W-1:0] buffer_q;
    logic [MAT_W-1:0] buffer_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             last_row;
    logic             beat_taken;

    // Next row moves into the top slot; the next index follows it.
    always_comb begin
        buffer_d   = buffer_q << ROW_W;
        count_d    = count_q + CW'(1);
        last_row   = (count_q == LAST_IDX);
        beat_taken = bus.enable & bus.dready;
    end

    // Load/emit state machine; enable low freezes every register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            buffer_q <= '0;
            count_q  <= '0;
        end else if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    if (bus.dsetFlag) begin
                        buffer_q <= bus.dats;
                        count_q  <= '0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (beat_taken) begin
                        if (last_row) begin
                            // Clearing here keeps count from ever wrapping
                            // and leaves datsOut at zero between matrices.
                            state_q  <= IDLE;
                            buffer_q <= '0;
                            count_q  <= '0;
                        end else begin
                            buffer_q <= buffer_d;
                            count_q  <= count_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Current row is the top slice of the buffer, element by element.
    genvar gi;
    generate
        for (gi = 0; gi < ROW_SIZE; gi++) begin : g_row_elem
            assign bus.datsOut[gi*DATA_SIZE +: DATA_SIZE] =
                buffer_q[MAT_W - ROW_W + gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    // Handshake flags are gated by enable so a frozen block advertises nothing;
    // reset also blocks a load in the cycle it is asserted.
    assign bus.dreadyFlag = (state_q == IDLE) & bus.enable & ~reset;
    assign bus.dvalidFlag = (state_q == SEND) & bus.enable;
    assign bus.dendFlag   = bus.dvalidFlag & last_row;
    assign bus.rowIdx     = count_q;

endmodule : row_emit_mdl

// File: tb/tb_row_emit_mdl.sv
// Directed bench for row_emit_mdl with DATA_SIZE=4, ROW_SIZE=2, COLUMN_SIZE=4.
// Each table row is one clock cycle: inputs held for that cycle and the
// outputs expected mid-cycle, before the edge that consumes those inputs.
module tb_row_emit_mdl;

    localparam int DS = 4;
    localparam int CS = 4;
    localparam int RS = 2;

    localparam logic [31:0] MX = 32'hA1B2C3D4;
    localparam logic [31:0] MY = 32'h11112222;
    localparam logic [31:0] MZ = 32'h5A3C96E7;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    row_emit_mdl_if #(.DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS)) bus ();

    row_emit_mdl #(.DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        set;
        logic [31:0] dats;
        logic        rdy;
        logic        exp_rdyf;
        logic [7:0]  exp_out;
        logic        exp_vld;
        logic        exp_end;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string nm, input logic rst, input logic en,
                       input logic set, input logic [31:0] d, input logic rdy,
                       input logic rdyf, input logic [7:0] o, input logic v,
                       input logic e, input logic [1:0] i);
        vec_t t;
        t.name = nm;   t.rst = rst;     t.en = en;      t.set = set;
        t.dats = d;    t.rdy = rdy;     t.exp_rdyf = rdyf;
        t.exp_out = o; t.exp_vld = v;   t.exp_end = e;  t.exp_idx = i;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic rst, input logic en, input logic set,
                         input logic [31:0] d, input logic rdy);
        reset        = rst;
        bus.enable   = en;
        bus.dsetFlag = set;
        bus.dats     = d;
        bus.dready   = rdy;
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end else begin
            $display("ok   %s: %h", nm, got);
        end
    endtask

    // Emit one matrix X with everything accepted, starting from IDLE.
    task automatic add_plain_stream(input string p);
        add({p, "_load"}, 0, 1, 1, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        add({p, "_r0"},   0, 1, 0, MX, 1, 0, 8'hA1, 1, 0, 2'd0);
        add({p, "_r1"},   0, 1, 0, MX, 1, 0, 8'hB2, 1, 0, 2'd1);
        add({p, "_r2"},   0, 1, 0, MX, 1, 0, 8'hC3, 1, 0, 2'd2);
        add({p, "_r3"},   0, 1, 0, MX, 1, 0, 8'hD4, 1, 1, 2'd3);
        add({p, "_idle"}, 0, 1, 0, MX, 1, 1, 8'h00, 0, 0, 2'd0);
    endtask

    logic [12:0] got_v;
    logic [12:0] exp_v;
    logic [31:0] rebuilt;
    int          beats;
    bit          done;
    bit          loaded;

    initial begin
        // Reset state
        add("rst_state", 1, 1, 0, 32'h0, 1, 0, 8'h00, 0, 0, 2'd0);
        // Basic stream
        add_plain_stream("basic");
        // Backpressure on the second beat for three cycles
        add("bp_load",  0, 1, 1, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        add("bp_r0",    0, 1, 0, MX, 1, 0, 8'hA1, 1, 0, 2'd0);
        add("bp_hold0", 0, 1, 0, MX, 0, 0, 8'hB2, 1, 0, 2'd1);
        add("bp_hold1", 0, 1, 0, MX, 0, 0, 8'hB2, 1, 0, 2'd1);
        add("bp_hold2", 0, 1, 0, MX, 0, 0, 8'hB2, 1, 0, 2'd1);
        add("bp_r1",    0, 1, 0, MX, 1, 0, 8'hB2, 1, 0, 2'd1);
        add("bp_r2",    0, 1, 0, MX, 1, 0, 8'hC3, 1, 0, 2'd2);
        add("bp_r3",    0, 1, 0, MX, 1, 0, 8'hD4, 1, 1, 2'd3);
        add("bp_idle",  0, 1, 0, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        // Enable freeze while C3 is presented
        add("en_load",  0, 1, 1, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        add("en_r0",    0, 1, 0, MX, 1, 0, 8'hA1, 1, 0, 2'd0);
        add("en_r1",    0, 1, 0, MX, 1, 0, 8'hB2, 1, 0, 2'd1);
        add("en_frz0",  0, 0, 0, MX, 1, 0, 8'hC3, 0, 0, 2'd2);
        add("en_frz1",  0, 0, 0, MX, 1, 0, 8'hC3, 0, 0, 2'd2);
        add("en_r2",    0, 1, 0, MX, 1, 0, 8'hC3, 1, 0, 2'd2);
        add("en_r3",    0, 1, 0, MX, 1, 0, 8'hD4, 1, 1, 2'd3);
        add("en_idle",  0, 1, 0, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        // Enable low in IDLE blocks a load
        add("en_off_set", 0, 0, 1, MX, 1, 0, 8'h00, 0, 0, 2'd0);
        add("en_on_noload", 0, 1, 0, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        // Load request during SEND is ignored
        add("ig_load",  0, 1, 1, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        add("ig_r0",    0, 1, 1, MY, 1, 0, 8'hA1, 1, 0, 2'd0);
        add("ig_r1",    0, 1, 1, MY, 1, 0, 8'hB2, 1, 0, 2'd1);
        add("ig_r2",    0, 1, 1, MY, 1, 0, 8'hC3, 1, 0, 2'd2);
        add("ig_r3",    0, 1, 1, MY, 1, 0, 8'hD4, 1, 1, 2'd3);
        add("ig_load2", 0, 1, 1, MY, 1, 1, 8'h00, 0, 0, 2'd0);
        add("ig_s0",    0, 1, 0, MY, 1, 0, 8'h11, 1, 0, 2'd0);
        add("ig_s1",    0, 1, 0, MY, 1, 0, 8'h11, 1, 0, 2'd1);
        add("ig_s2",    0, 1, 0, MY, 1, 0, 8'h22, 1, 0, 2'd2);
        add("ig_s3",    0, 1, 0, MY, 1, 0, 8'h22, 1, 1, 2'd3);
        add("ig_idle",  0, 1, 0, MY, 1, 1, 8'h00, 0, 0, 2'd0);
        // Reset after B2 is accepted
        add("rm_load",  0, 1, 1, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        add("rm_r0",    0, 1, 0, MX, 1, 0, 8'hA1, 1, 0, 2'd0);
        add("rm_r1",    0, 1, 0, MX, 1, 0, 8'hB2, 1, 0, 2'd1);
        add("rm_assert",1, 1, 0, MX, 1, 0, 8'hC3, 1, 0, 2'd2);
        add("rm_held",  1, 1, 0, MX, 1, 0, 8'h00, 0, 0, 2'd0);
        add_plain_stream("rm_fresh");
        // Reset together with dsetFlag: no load
        add("rs_both",    1, 1, 1, MY, 1, 0, 8'h00, 0, 0, 2'd0);
        add("rs_noload",  0, 1, 0, MY, 1, 1, 8'h00, 0, 0, 2'd0);
        // Back-to-back with dsetFlag held high
        add("bb_load1", 0, 1, 1, MX, 1, 1, 8'h00, 0, 0, 2'd0);
        add("bb_a0",    0, 1, 1, MY, 1, 0, 8'hA1, 1, 0, 2'd0);
        add("bb_a1",    0, 1, 1, MY, 1, 0, 8'hB2, 1, 0, 2'd1);
        add("bb_a2",    0, 1, 1, MY, 1, 0, 8'hC3, 1, 0, 2'd2);
        add("bb_a3",    0, 1, 1, MY, 1, 0, 8'hD4, 1, 1, 2'd3);
        add("bb_gap",   0, 1, 1, MY, 1, 1, 8'h00, 0, 0, 2'd0);
        add("bb_b0",    0, 1, 0, MY, 1, 0, 8'h11, 1, 0, 2'd0);
        add("bb_b1",    0, 1, 0, MY, 1, 0, 8'h11, 1, 0, 2'd1);
        add("bb_b2",    0, 1, 0, MY, 1, 0, 8'h22, 1, 0, 2'd2);
        add("bb_b3",    0, 1, 0, MY, 1, 0, 8'h22, 1, 1, 2'd3);
        add("bb_idle",  0, 1, 0, MY, 1, 1, 8'h00, 0, 0, 2'd0);

        // Bring the block out of its unknown power-up state.
        drive(1, 1, 0, 32'h0, 0);
        repeat (2) @(posedge clock);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clock);
            drive(vecs[k].rst, vecs[k].en, vecs[k].set, vecs[k].dats, vecs[k].rdy);
            #1;
            got_v = {bus.dreadyFlag, bus.datsOut, bus.dvalidFlag, bus.dendFlag, bus.rowIdx};
            exp_v = {vecs[k].exp_rdyf, vecs[k].exp_out, vecs[k].exp_vld,
                     vecs[k].exp_end, vecs[k].exp_idx};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s: got rdyf=%b out=%h vld=%b end=%b idx=%0d required rdyf=%b out=%h vld=%b end=%b idx=%0d",
                         vecs[k].name, got_v[12], got_v[11:4], got_v[3], got_v[2], got_v[1:0],
                         exp_v[12], exp_v[11:4], exp_v[3], exp_v[2], exp_v[1:0]);
            end else begin
                $display("ok   %s: rdyf=%b out=%h vld=%b end=%b idx=%0d",
                         vecs[k].name, got_v[12], got_v[11:4], got_v[3], got_v[2], got_v[1:0]);
            end
        end

        // Loopback under irregular backpressure: rebuild the matrix from the
        // accepted rows and check index order and the last-row flag.
        @(negedge clock);
        drive(0, 1, 1, MZ, 0);
        #1;
        loaded = 1'b0;
        for (int c = 0; c < 10 && !loaded; c++) begin
            if (bus.dreadyFlag) loaded = 1'b1;
            else begin
                @(negedge clock);
                #1;
            end
        end
        check("lb_load_seen", {31'd0, loaded}, 32'd1);

        rebuilt = 32'h0;
        beats   = 0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            drive(0, 1, 0, 32'h0, (c % 3) != 1);
            #1;
            if (bus.dvalidFlag && bus.dready) begin
                check("lb_rowidx", {30'd0, bus.rowIdx}, beats);
                check("lb_end_flag", {31'd0, bus.dendFlag}, {31'd0, beats == CS - 1});
                rebuilt = {rebuilt[23:0], bus.datsOut};
                beats++;
                if (bus.dendFlag) done = 1'b1;
            end
        end
        check("lb_beats", beats, CS);
        check("lb_matrix", rebuilt, MZ);

        @(negedge clock);
        drive(0, 1, 0, 32'h0, 1);
        #1;
        check("lb_ready_after", {31'd0, bus.dreadyFlag}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_row_emit_mdl
